// File: rtl/cache_pkg.sv
// Shared parameters and FSM state type for the tag lookup controller.
package cache_pkg;

    localparam int TAG_W = 18;
    localparam int IDX_W = 8;
    localparam int WAYS  = 4;
    localparam int WAY_W = 2;
    localparam int SETS  = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT1   = 3'd1,
        WAIT2   = 3'd2,
        COMPARE = 3'd3,
        FILL    = 3'd4
    } state_t;

endpackage

// File: rtl/tag_cmp4.sv
// Four-way tag compare with lowest-way priority encode and victim selection.
module tag_cmp4
    import cache_pkg::*;
(
    input  logic [WAYS*TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]      tag,
    input  logic [WAYS-1:0]       valid,
    input  logic [WAY_W-1:0]      rr,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [WAY_W-1:0]      victim,
    output logic                  victim_from_rr
);

    logic [WAYS-1:0] match;

    // Per-way match, then priority encodes; scanning downwards leaves the lowest way selected.
    always_comb begin
        match          = '0;
        hit_way        = '0;
        victim         = rr;
        victim_from_rr = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid[w] && (tags[w*TAG_W +: TAG_W] == tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid[w]) begin
                victim         = WAY_W'(w);
                victim_from_rr = 1'b0;
            end
        end
        hit = |match;
    end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag lookup controller: accepts a lookup, waits out the 2-cycle tag RAM read,
// reports hit/way (or victim on miss), and optionally fills the victim way.
// Handshake: a request transfers on any rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and resp_valid is
// a single-cycle pulse with no back-pressure.
module tag_lookup_ctrl
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDX_W-1:0]       req_index,
    input  logic [TAG_W-1:0]       req_tag,
    input  logic                   req_alloc,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [WAY_W-1:0]       resp_way,
    input  logic                   flush,
    output logic [IDX_W-1:0]       tram_r_index,
    input  logic [WAYS*TAG_W-1:0]  tram_tag_out,
    output logic [IDX_W+WAY_W-1:0] tram_w_index,
    output logic [TAG_W-1:0]       tram_tag_in,
    output logic                   tram_wr_en,
    output state_t                 dbg_state
);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic             alloc_q;
    logic [WAYS-1:0]  vrow_q;
    logic [WAY_W-1:0] victim_q;
    logic [WAY_W-1:0] rr_q;
    logic [WAYS-1:0]  valid_q [SETS];

    logic             accept;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             victim_from_rr;

    assign accept       = req_valid && req_ready;
    assign tram_r_index = idx_q;
    assign dbg_state    = state;

    tag_cmp4 u_cmp (
        .tags           (tram_tag_out),
        .tag            (tag_q),
        .valid          (vrow_q),
        .rr             (rr_q),
        .hit            (hit),
        .hit_way        (hit_way),
        .victim         (victim),
        .victim_from_rr (victim_from_rr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore-style outputs; response fields are zero outside COMPARE.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_hit     = 1'b0;
        resp_way     = '0;
        tram_wr_en   = 1'b0;
        tram_w_index = '0;
        tram_tag_in  = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = WAIT1;
            end
            WAIT1: state_next = WAIT2;
            WAIT2: state_next = COMPARE;
            COMPARE: begin
                resp_valid = 1'b1;
                resp_hit   = hit;
                resp_way   = hit ? hit_way : victim;
                state_next = (!hit && alloc_q) ? FILL : IDLE;
            end
            FILL: begin
                tram_wr_en   = 1'b1;
                tram_w_index = {idx_q, victim_q};
                tram_tag_in  = tag_q;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture (valid row snapshotted at accept), victim latch and round-robin advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            tag_q    <= '0;
            alloc_q  <= 1'b0;
            vrow_q   <= '0;
            victim_q <= '0;
            rr_q     <= '0;
        end else begin
            if (accept) begin
                idx_q   <= req_index;
                tag_q   <= req_tag;
                alloc_q <= req_alloc;
                vrow_q  <= valid_q[req_index];
            end
            if (state == COMPARE) begin
                victim_q <= victim;
                if (!hit && alloc_q && victim_from_rr) begin
                    rr_q <= rr_q + 1'b1;
                end
            end
        end
    end

    // Valid-bit array: reset and flush clear everything and take priority over a fill.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (state == FILL) begin
            valid_q[idx_q][victim_q] <= 1'b1;
        end
    end

endmodule

// File: doc/tag_lookup_ctrl.md
TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on posedge; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: req_valid in 1 lookup request; req_ready out 1 ready to accept; req_index in 8 set index; req_tag in 18 tag to match; req_alloc in 1 allocate on miss.
REQ-003 SHALL have ports: resp_valid out 1 one-cycle result pulse; resp_hit out 1 tag matched; resp_way out 2 hit way, or victim way on miss.
REQ-004 SHALL have ports: flush in 1 invalidate all ways in all sets.
REQ-005 SHALL have tag-RAM ports: tram_r_index out 8; tram_tag_out in 72 (way w at bits [18w+17:18w]); tram_w_index out 10 ({set, way}); tram_tag_in out 18; tram_wr_en out 1.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT1, WAIT2, COMPARE, FILL.
REQ-007 SHALL assert req_ready only in IDLE; a request is accepted when req_valid & req_ready at a clock edge, capturing index, tag and alloc into registers.
REQ-008 SHALL drive tram_r_index from the captured index register at all times.
REQ-009 SHALL transition IDLE->WAIT1 on accept, WAIT1->WAIT2, and WAIT2->COMPARE unconditionally; tram_tag_out SHALL be sampled only in COMPARE, because the tag RAM has 2-cycle read latency.
REQ-010 SHALL keep a 256x4 valid-bit array in flops; way w hits when valid[set][w] and the tram_tag_out field for w equals the captured tag.
REQ-011 SHALL, in COMPARE, pulse resp_valid for exactly one cycle with resp_hit = any way hits and resp_way = the lowest-numbered hitting way; accept-to-resp_valid latency is 3 cycles.
REQ-012 SHALL, on a miss, report as resp_way the victim, which is the lowest-numbered invalid way of the set, or the global 2-bit round-robin counter value if all four ways are valid.
REQ-013 SHALL advance the round-robin counter (mod 4, wraps 3->0) only when it supplied the victim and the miss allocates.
REQ-014 SHALL go COMPARE->FILL on a miss with alloc=1, and COMPARE->IDLE otherwise.
REQ-015 SHALL, in FILL, assert tram_wr_en for exactly one cycle with tram_w_index = {set, victim} and tram_tag_in = captured tag, set valid[set][victim], then return to IDLE.
REQ-016 SHALL hold tram_wr_en low in every state except FILL.
REQ-017 SHALL, when flush is sampled high, clear all valid bits at that edge regardless of state; if flush coincides with the FILL valid-set, flush SHALL win; an in-flight lookup SHALL complete using the pre-flush valid bits it already sampled.
REQ-018 SHALL guarantee that a request for the same set, accepted after a FILL, observes the new tag, since accept occurs no earlier than the cycle after FILL.
REQ-019 SHALL drive resp_hit=0 and resp_way=0 whenever resp_valid=0.

Reset
REQ-020 SHALL, on rst, enter IDLE, clear all valid bits, zero the round-robin counter and all captured registers, and drive req_ready=1 on the first cycle after reset, with resp_valid=0, tram_wr_en=0 and all other outputs 0.
REQ-021 SHALL, if rst occurs mid-lookup or in FILL, abandon the operation with no response and no write after the reset edge.

Structure
REQ-022 SHALL take TAG_W=18, IDX_W=8, WAYS=4 and the FSM state enum from shared package cache_pkg.
REQ-023 SHALL place the 4-way compare and priority encode in one combinational sub-module, tag_cmp4; the tag RAM is instantiated by the parent, not inside this block.

Verification
REQ-024 SHALL pass: reset, then lookup set 0x05 tag 0x12345 alloc=1 -> resp_valid 3 cycles after accept, hit=0, way=0; next cycle tram_wr_en=1, w_index=0x014, tag_in=0x12345.
REQ-025 SHALL pass: repeat the same lookup -> hit=1, way=0, no write.
REQ-026 SHALL pass: fill set 0x05 ways 0-3 with tags A-D, then miss tag E alloc=1 -> victim way 0 (RR=0), and a following miss on F -> victim way 1.
REQ-027 SHALL pass: miss with alloc=0 -> hit=0, return to IDLE, tram_wr_en never asserts.
REQ-028 SHALL pass: flush asserted during FILL -> after the write, valid[set][way]=0 and a re-lookup misses.
REQ-029 SHALL pass: rst pulsed in WAIT2 -> no resp_valid, no tram_wr_en, req_ready=1 the cycle after reset.
